inst_fetch_mem: RTL and testbench

- Parametrised instruction memory for the soft processor.
- Holds the program image and returns the addressed instruction one clock after a fetch request.
- Adds features the first-generation memory lacks:
  - byte or word PC addressing
  - range and alignment checking
  - stall, flush and a valid flag
  - a runtime program-load write port, so images can be loaded without re-synthesis.

---
 rtl/inst_fetch_mem.sv | 118 +++++++++++
 tb/tb_inst_fetch_mem.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_mem.sv
`default_nettype none
// ============================================================================
// inst_fetch_mem : instruction memory with range-checked, registered fetch
//                  and a runtime program-load write port.
// Revision: 1.0
// ============================================================================
module inst_fetch_mem #(
    parameter int                          DATA_WIDTH = 32,
    parameter int                          DEPTH      = 128,
    parameter int                          ADDR_WIDTH = 7,
    parameter bit                          BYTE_ADDR  = 1'b1,
    parameter logic [DATA_WIDTH-1:0]       NOP_WORD   = '0,
    parameter logic [DEPTH*DATA_WIDTH-1:0] INIT_IMAGE = {DEPTH{NOP_WORD}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc,
    input  logic                  fetch_req,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_valid,
    output logic                  fault
);

    localparam int HI_LSB = BYTE_ADDR ? ADDR_WIDTH + 2 : ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

    function automatic mem_t f_init();
        mem_t img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = INIT_IMAGE[i*DATA_WIDTH +: DATA_WIDTH];
        end
        return img;
    endfunction

    // Power-up contents come from the build-time image; reset never touches them.
    mem_t mem_q = f_init();

    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;

    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic                  hi_zero;
    logic                  aligned;
    logic                  in_range;
    logic                  fetch_ok;
    logic                  load_ok;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] rd_data;

    generate
        if (BYTE_ADDR) begin : g_byte
            assign fetch_idx = pc[ADDR_WIDTH+1:2];
            assign aligned   = (pc[1:0] == 2'b00);
        end else begin : g_word
            assign fetch_idx = pc[ADDR_WIDTH-1:0];
            assign aligned   = 1'b1;
        end
    endgenerate

    // Upper pc bits must be zero so an oversize pc can never alias a low word.
    assign hi_zero  = ((pc >> HI_LSB) == 32'd0);
    assign in_range = (32'(fetch_idx) < 32'(DEPTH));
    assign fetch_ok = hi_zero & aligned & in_range;
    assign load_ok  = (32'(load_addr) < 32'(DEPTH));
    assign bypass   = load_en & load_ok & (load_addr == fetch_idx);
    assign rd_data  = bypass ? load_data : mem_q[fetch_idx];

    always_ff @(posedge clk) begin
        if (!reset && load_en && load_ok) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_comb begin
        inst_d  = inst_q;
        valid_d = valid_q;
        fault_d = fault_q;
        if (flush) begin
            inst_d  = NOP_WORD;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (!stall) begin
            if (fetch_req) begin
                inst_d  = fetch_ok ? rd_data : NOP_WORD;
                valid_d = 1'b1;
                fault_d = ~fetch_ok;
            end else begin
                valid_d = 1'b0;
                fault_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q  <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign fault      = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_mem.sv
`default_nettype none
// Testbench for inst_fetch_mem: directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_inst_fetch_mem;

    localparam int          DW    = 32;
    localparam int          DEP   = 128;
    localparam int          AW    = 7;
    localparam logic [31:0] NOP_W = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   pc = '0;
    logic          fetch_req = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic [DW-1:0] inst;
    logic          inst_valid;
    logic          fault;

    inst_fetch_mem #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEP),
        .ADDR_WIDTH(AW),
        .BYTE_ADDR (1'b1),
        .NOP_WORD  (NOP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .fetch_req (fetch_req),
        .stall     (stall),
        .flush     (flush),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .inst      (inst),
        .inst_valid(inst_valid),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] m_mem [DEP];
    logic [31:0] m_inst  = NOP_W;
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain address arithmetic over a word array.
    task automatic model_edge();
        int unsigned word;
        bit          ok;
        word = pc / 4;
        ok   = (pc % 4 == 0) && (pc / 4 < DEP);
        if (reset) begin
            m_inst = NOP_W; m_valid = 1'b0; m_fault = 1'b0;
        end else begin
            if (flush) begin
                m_inst = NOP_W; m_valid = 1'b0; m_fault = 1'b0;
            end else if (stall) begin
                // outputs hold
            end else if (fetch_req) begin
                if (ok) m_inst = (load_en && int'(load_addr) == word) ? load_data : m_mem[word];
                else    m_inst = NOP_W;
                m_valid = 1'b1;
                m_fault = !ok;
            end else begin
                m_valid = 1'b0; m_fault = 1'b0;
            end
            if (load_en && int'(load_addr) < DEP) m_mem[load_addr] = load_data;
        end
    endtask

    task automatic step(input logic rst, input logic [31:0] p, input logic fr,
                        input logic st, input logic fl, input logic le,
                        input logic [AW-1:0] la, input logic [31:0] ld);
        @(negedge clk);
        reset = rst; pc = p; fetch_req = fr; stall = st; flush = fl;
        load_en = le; load_addr = la; load_data = ld;
        @(posedge clk);
        model_edge();
        #1;
        chk("inst",  inst, m_inst);
        chk("valid", {31'd0, inst_valid}, {31'd0, m_valid});
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
    endtask

    task automatic fetch(input logic [31:0] p);
        step(1'b0, p, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < DEP; i++) m_mem[i] = NOP_W;

        step(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("rst_inst", inst, NOP_W);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);

        for (int i = 0; i < 4; i++)
            step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, AW'(i), 32'h1111_1111 * (i + 1));

        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4));
            chk("b2b_inst", inst, 32'h1111_1111 * (i + 1));
            chk("b2b_valid", {31'd0, inst_valid}, 32'd1);
        end

        fetch(32'h6);
        chk("misalign_fault", {31'd0, fault}, 32'd1);
        chk("misalign_inst", inst, NOP_W);
        fetch(32'h200);
        chk("range_fault", {31'd0, fault}, 32'd1);
        chk("range_valid", {31'd0, inst_valid}, 32'd1);

        fetch(32'h190);
        chk("unused_word", inst, NOP_W);

        fetch(32'h4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
            chk("stall_inst", inst, 32'h2222_2222);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
        end
        fetch(32'h8);
        chk("post_stall", inst, 32'h3333_3333);

        step(1'b0, 32'h8, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
        chk("flush_valid", {31'd0, inst_valid}, 32'd0);
        chk("flush_inst", inst, NOP_W);

        step(1'b0, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1, AW'(2), 32'hDEAD_BEEF);
        chk("write_first", inst, 32'hDEAD_BEEF);

        fetch(32'h4);
        step(1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        chk("rst_stall_inst", inst, NOP_W);
        chk("rst_stall_valid", {31'd0, inst_valid}, 32'd0);
        fetch(32'h0);
        chk("retained", inst, 32'h1111_1111);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] p;
            int unsigned sel;
            sel = $urandom_range(0, 99);
            if (sel < 70)      p = 32'($urandom_range(0, DEP - 1) * 4);
            else if (sel < 85) p = 32'($urandom_range(0, DEP - 1) * 4 + $urandom_range(1, 3));
            else if (sel < 92) p = 32'($urandom_range(DEP, DEP + 8) * 4);
            else               p = $urandom;
            step($urandom_range(0, 99) < 3,
                 p,
                 $urandom_range(0, 99) < 75,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 30,
                 AW'($urandom_range(0, DEP - 1)),
                 $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
